// File: rtl/lda_pkg.sv
// Shared types and defaults for the LDA command scheduler and its arbiter.
// Holds the FSM state encoding, coordinate/colour typedefs and an index-wrap helper.
package lda_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam int LDA_X_W         = 9;
  localparam int LDA_Y_W         = 8;
  localparam int LDA_COLOR_W     = 3;
  localparam int LDA_TIMEOUT_CYC = 65535;

  typedef logic [LDA_X_W-1:0]     coord_x_t;
  typedef logic [LDA_Y_W-1:0]     coord_y_t;
  typedef logic [LDA_COLOR_W-1:0] color_t;

  // Folds an index in [0, 2n) back into [0, n); callers never exceed 2n-1.
  function automatic int wrapIdx(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping around. The pointer register lives in the caller.
module rr_arbiter
  import lda_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grantIdx_o,
  output logic               anyReq_o
);

  int cand;

  always_comb begin
    grant_o    = '0;
    grantIdx_o = '0;
    anyReq_o   = 1'b0;
    cand       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = wrapIdx(int'(ptr_i) + k, NUM_REQ);
      if (!anyReq_o && req_i[IDX_W'(cand)]) begin
        anyReq_o                = 1'b1;
        grant_o[IDX_W'(cand)]   = 1'b1;
        grantIdx_o              = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/lda_cmd_scheduler.sv
// Shares one line-draw engine between NUM_REQ requesters: round-robin accept, start
// pulse, wait for done under a watchdog, then a one-cycle response to the winner.
module lda_cmd_scheduler
  import lda_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int X_W         = LDA_X_W,
  parameter int Y_W         = LDA_Y_W,
  parameter int COLOR_W     = LDA_COLOR_W,
  parameter int TIMEOUT_CYC = LDA_TIMEOUT_CYC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*X_W-1:0]   req_x0,
  input  logic [NUM_REQ*X_W-1:0]   req_x1,
  input  logic [NUM_REQ*Y_W-1:0]   req_y0,
  input  logic [NUM_REQ*Y_W-1:0]   req_y1,
  input  logic [NUM_REQ*COLOR_W-1:0] req_color,
  output logic                     lda_start,
  output logic [X_W-1:0]           lda_x0,
  output logic [X_W-1:0]           lda_x1,
  output logic [Y_W-1:0]           lda_y0,
  output logic [Y_W-1:0]           lda_y1,
  output logic [COLOR_W-1:0]       lda_color,
  input  logic                     lda_done,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic                     rsp_err,
  output logic                     busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rrPtr_q;
  logic [IDX_W-1:0]   grantIdx_q;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               err_q, err_d;
  logic [X_W-1:0]     x0_q, x1_q;
  logic [Y_W-1:0]     y0_q, y1_q;
  logic [COLOR_W-1:0] color_q;

  logic [NUM_REQ-1:0] arbGrant;
  logic [IDX_W-1:0]   arbIdx;
  logic               anyReq;
  logic               accept;

  logic [X_W-1:0]     reqX0Arr    [NUM_REQ];
  logic [X_W-1:0]     reqX1Arr    [NUM_REQ];
  logic [Y_W-1:0]     reqY0Arr    [NUM_REQ];
  logic [Y_W-1:0]     reqY1Arr    [NUM_REQ];
  logic [COLOR_W-1:0] reqColorArr [NUM_REQ];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i      (req_valid),
    .ptr_i      (rrPtr_q),
    .grant_o    (arbGrant),
    .grantIdx_o (arbIdx),
    .anyReq_o   (anyReq)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      reqX0Arr[i]    = req_x0[i*X_W +: X_W];
      reqX1Arr[i]    = req_x1[i*X_W +: X_W];
      reqY0Arr[i]    = req_y0[i*Y_W +: Y_W];
      reqY1Arr[i]    = req_y1[i*Y_W +: Y_W];
      reqColorArr[i] = req_color[i*COLOR_W +: COLOR_W];
    end
  end

  assign accept = (state_q == S_IDLE) && anyReq;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  // Done takes priority over watchdog expiry when both land in the same cycle.
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (anyReq) state_d = S_START;
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lda_done) begin
          state_d = S_RESP;
          err_d   = 1'b0;
        end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready = '0;
    lda_start = 1'b0;
    rsp_valid = '0;
    rsp_err   = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy      = 1'b0;
        req_ready = arbGrant;
      end
      S_START: begin
        lda_start = 1'b1;
      end
      S_RESP: begin
        rsp_valid[grantIdx_q] = 1'b1;
        rsp_err               = err_q;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // Command latch and round-robin pointer only move on an accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rrPtr_q    <= '0;
      grantIdx_q <= '0;
      x0_q       <= '0;
      x1_q       <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      color_q    <= '0;
    end else if (accept) begin
      rrPtr_q    <= IDX_W'(wrapIdx(int'(arbIdx) + 1, NUM_REQ));
      grantIdx_q <= arbIdx;
      x0_q       <= reqX0Arr[arbIdx];
      x1_q       <= reqX1Arr[arbIdx];
      y0_q       <= reqY0Arr[arbIdx];
      y1_q       <= reqY1Arr[arbIdx];
      color_q    <= reqColorArr[arbIdx];
    end
  end

  assign lda_x0    = x0_q;
  assign lda_x1    = x1_q;
  assign lda_y0    = y0_q;
  assign lda_y1    = y1_q;
  assign lda_color = color_q;

endmodule
